// File: rtl/md_if.sv
// Multiply/divide unit operand/result bundle.
// Directions are named from the md_unit's point of view (_i into the unit, _o out of it).
//   start_i  : EX instruction is an MD op this cycle (qualifies md_op_i)
//   md_op_i  : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   a_i/b_i  : forwarded rs/rt operands
//   busy_o   : registered, high while a mult/div is in flight
//   hi_o/lo_o: architectural HI/LO registers
// master: the EX stage driving operands; slave: md_unit.
interface md_if;
    logic        start_i;
    logic [2:0]  md_op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, md_op_i, a_i, b_i,
        input  busy_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, md_op_i, a_i, b_i,
        output busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// mult/multu/div/divu compute their result at the accept edge, then busy_o stays high for a
// fixed MULT_CYCLES/DIV_CYCLES before HI/LO are updated. mthi/mtlo write in a single cycle.
// Ports:
//   clk   : pipeline clock
//   reset : asynchronous active-high reset
//   bus   : md_if.slave (start_i, md_op_i, a_i, b_i in; busy_o, hi_o, lo_o out)
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        res_wr_q, res_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic accept_mult, accept_div, accept_mthi, accept_mtlo;
    logic done;

    // Ops are only accepted while idle; anything arriving during busy is dropped.
    always_comb begin
        accept_mult = 1'b0;
        accept_div  = 1'b0;
        accept_mthi = 1'b0;
        accept_mtlo = 1'b0;
        if (state_q == StIdle && bus.start_i) begin
            case (bus.md_op_i)
                OpMult, OpMultu: accept_mult = 1'b1;
                OpDiv, OpDivu:   accept_div  = 1'b1;
                OpMthi:          accept_mthi = 1'b1;
                OpMtlo:          accept_mtlo = 1'b1;
                default:         ;
            endcase
        end
    end

    // Arithmetic.
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, divisor;
    logic [31:0] q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        div_by_zero;

    always_comb begin
        prod_s = $signed({{32{bus.a_i[31]}}, bus.a_i}) * $signed({{32{bus.b_i[31]}}, bus.b_i});
        prod_u = {32'd0, bus.a_i} * {32'd0, bus.b_i};

        div_by_zero = (bus.b_i == 32'd0);
        // Divide by zero never reaches HI/LO; a dummy divisor keeps the datapath X-free.
        divisor     = div_by_zero ? 32'd1 : bus.b_i;

        // Signed division on magnitudes: truncation toward zero, remainder follows dividend.
        // -2^31 / -1 wraps to 0x80000000 since its magnitude is representable unsigned.
        abs_a = bus.a_i[31] ? (32'd0 - bus.a_i) : bus.a_i;
        abs_b = divisor[31] ? (32'd0 - divisor) : divisor;
        q_mag = abs_a / abs_b;
        r_mag = abs_a % abs_b;
        q_s   = (bus.a_i[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = bus.a_i[31] ? (32'd0 - r_mag) : r_mag;

        q_u = bus.a_i / divisor;
        r_u = bus.a_i % divisor;
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept_mult || accept_div) state_d = StBusy;
            StBusy: if (cnt_q == 8'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.busy_o = (state_q == StBusy);
        done       = (state_q == StBusy) && (cnt_q == 8'd1);
    end

    // Datapath next state.
    always_comb begin
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (accept_mult) begin
            cnt_d    = 8'(MULT_CYCLES);
            res_wr_d = 1'b1;
            if (bus.md_op_i == OpMult) begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end else begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
        end else if (accept_div) begin
            cnt_d    = 8'(DIV_CYCLES);
            res_wr_d = !div_by_zero;
            if (bus.md_op_i == OpDiv) begin
                res_hi_d = r_s;
                res_lo_d = q_s;
            end else begin
                res_hi_d = r_u;
                res_lo_d = q_u;
            end
        end else if (accept_mthi) begin
            hi_d = bus.a_i;
        end else if (accept_mtlo) begin
            lo_d = bus.a_i;
        end

        if (state_q == StBusy) begin
            cnt_d = cnt_q - 8'd1;
        end

        if (done && res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 8'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: inputs change and outputs are sampled on the falling edge.
module tb_md_unit;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    md_if bus();

    md_unit #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a_v, input logic [31:0] b_v);
        bus.start_i = 1'b1;
        bus.md_op_i = op;
        bus.a_i     = a_v;
        bus.b_i     = b_v;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.md_op_i = 3'd0;
    endtask

    // Expect busy high with HI/LO unchanged for n cycles.
    task automatic hold_busy(input string tag, input int n,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
            chk({tag, "_hi_hold"}, bus.hi_o, old_hi);
            chk({tag, "_lo_hold"}, bus.lo_o, old_lo);
            @(negedge clk);
        end
    endtask

    task automatic expect_done(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
        chk({tag, "_busy_end"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, "_hi"}, bus.hi_o, e_hi);
        chk({tag, "_lo"}, bus.lo_o, e_lo);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.md_op_i = 3'd0;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;

        repeat (2) @(negedge clk);
        expect_done("reset", 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // mult -3 * 4 = -12
        issue(3'd1, 32'hFFFF_FFFD, 32'd4);
        hold_busy("mult", MultN, 32'd0, 32'd0);
        expect_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        // multu 0xFFFFFFFF * 2
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        hold_busy("multu", MultN, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        expect_done("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        // div -7 / 2 -> q=-3, r=-1
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        hold_busy("div", DivN, 32'h0000_0001, 32'hFFFF_FFFE);
        expect_done("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu same operands
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        hold_busy("divu", DivN, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        expect_done("divu", 32'h0000_0001, 32'h7FFF_FFFC);

        // -2^31 / -1 wraps
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        hold_busy("divovf", DivN, 32'h0000_0001, 32'h7FFF_FFFC);
        expect_done("divovf", 32'h0000_0000, 32'h8000_0000);

        // mthi / mtlo single-cycle
        issue(3'd5, 32'h11, 32'hDEAD_BEEF);
        expect_done("mthi", 32'h11, 32'h8000_0000);
        issue(3'd6, 32'h22, 32'hDEAD_BEEF);
        expect_done("mtlo", 32'h11, 32'h22);

        // div by zero: full latency, HI/LO untouched
        issue(3'd3, 32'h1234, 32'd0);
        hold_busy("divz", DivN, 32'h11, 32'h22);
        expect_done("divz", 32'h11, 32'h22);

        // mtlo right after, busy never high
        issue(3'd6, 32'h5, 32'd0);
        expect_done("mtlo5", 32'h11, 32'h5);
        @(negedge clk);
        expect_done("mtlo5_next", 32'h11, 32'h5);

        // md_op none/reserved do nothing
        issue(3'd0, 32'hAAAA_AAAA, 32'd3);
        expect_done("op0", 32'h11, 32'h5);
        issue(3'd7, 32'hAAAA_AAAA, 32'd3);
        expect_done("op7", 32'h11, 32'h5);

        // mult 3*5 with a divu pulse on busy cycle 2 that must be ignored
        issue(3'd1, 32'd3, 32'd5);
        hold_busy("mign", 1, 32'h11, 32'h5);
        bus.start_i = 1'b1;
        bus.md_op_i = 3'd4;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        hold_busy("mign2", 1, 32'h11, 32'h5);
        bus.start_i = 1'b0;
        bus.md_op_i = 3'd0;
        hold_busy("mign3", MultN - 2, 32'h11, 32'h5);
        expect_done("mign", 32'd0, 32'd15);
        @(negedge clk);
        expect_done("mign_after", 32'd0, 32'd15);

        // mult 7*9 with async reset on cycle 3
        issue(3'd1, 32'd7, 32'd9);
        hold_busy("mrst", 2, 32'd0, 32'd15);
        reset = 1'b1;
        #1;
        expect_done("mrst_now", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (MultN + 2) @(negedge clk);
        expect_done("mrst_late", 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
